// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
// SIPO_PARITY_EN adds a trailing even-parity bit to every frame.
package sipo_pkg;

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

`ifdef SIPO_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Wide enough to count a full frame, including the optional parity bit.
  function automatic int cnt_width(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial-in / word-out handshake bundle; slave is the deserializer side.
// m_perr exists only when SIPO_PARITY_EN is defined.
interface sipo_deser_if #(parameter int WIDTH = 8);
  logic             s_valid;
  logic             s_data;
  logic             s_ready;
  logic             sync;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
`ifdef SIPO_PARITY_EN
  logic             m_perr;

  modport master (output s_valid, s_data, sync, m_ready,
                  input  s_ready, m_data, m_valid, m_perr);
  modport slave  (input  s_valid, s_data, sync, m_ready,
                  output s_ready, m_data, m_valid, m_perr);
`else
  modport master (output s_valid, s_data, sync, m_ready,
                  input  s_ready, m_data, m_valid);
  modport slave  (input  s_valid, s_data, sync, m_ready,
                  output s_ready, m_data, m_valid);
`endif
endinterface

// File: rtl/sipo_out_reg.sv
// Single-entry valid/ready holding register for completed words.
// A load in the same cycle as a consume keeps m_valid set.
module sipo_out_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  output logic          slot_free
);

  assign slot_free = !m_valid || m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_data  <= '0;
      m_valid <= 1'b0;
    end else if (load) begin
      m_data  <= din;
      m_valid <= 1'b1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Parametrised serial-to-parallel deserializer with frame resync.
// Define SIPO_PARITY_EN to append an even-parity bit and report m_perr.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic        clk,
  input logic        rst,
  sipo_deser_if.slave bus
);

  localparam int FRAME = WIDTH + PAR_BITS;
  localparam int CW    = cnt_width(WIDTH);
  localparam int DW    = WIDTH + PAR_BITS;

  logic [FRAME-1:0] sh, sh_nxt, word_src;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] word;
  logic [DW-1:0]    din, q;
  state_t           state;
  logic             acc, last, slot_free, load;

  // FULL is simply a counter sitting at FRAME while the output slot is busy.
  assign state       = (cnt == CW'(FRAME)) ? FULL : FILL;
  assign bus.s_ready = !rst && (state == FILL);
  assign acc         = bus.s_valid && bus.s_ready;
  assign last        = (cnt == CW'(FRAME - 1)) && !bus.sync;

  assign sh_nxt = MSB_FIRST ? {sh[FRAME-2:0], bus.s_data}
                            : {bus.s_data, sh[FRAME-1:1]};

  // Completing in FILL forwards the incoming bit directly, so there is no bubble.
  assign word_src = (state == FULL) ? sh : sh_nxt;
  assign word     = MSB_FIRST ? word_src[FRAME-1:PAR_BITS] : word_src[WIDTH-1:0];

`ifdef SIPO_PARITY_EN
  logic par;
  assign par = MSB_FIRST ? word_src[0] : word_src[FRAME-1];
  assign din = {(^word) ^ par, word};
`else
  assign din = word;
`endif

  assign load = slot_free && ((state == FULL) || (acc && last));

  always_ff @(posedge clk) begin
    if (rst) begin
      sh  <= '0;
      cnt <= '0;
    end else if (state == FULL) begin
      if (slot_free) cnt <= '0;
    end else begin
      if (acc) sh <= sh_nxt;
      // Old partial bits need no clearing: a full frame shifts them all out.
      if (bus.sync)
        cnt <= acc ? CW'(1) : '0;
      else if (acc)
        cnt <= (last && slot_free) ? '0 : cnt + CW'(1);
    end
  end

  sipo_out_reg #(.DW(DW)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .din       (din),
    .m_ready   (bus.m_ready),
    .m_data    (q),
    .m_valid   (bus.m_valid),
    .slot_free (slot_free)
  );

  assign bus.m_data = q[WIDTH-1:0];
`ifdef SIPO_PARITY_EN
  assign bus.m_perr = q[WIDTH];
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Drives an MSB-first and an LSB-first instance in lockstep against a frame-level model.
// Build with SIPO_PARITY_EN to also cover the parity frame bit and m_perr.
module tb_sipo_deser;
  import sipo_pkg::PAR_BITS;

  localparam int W   = 8;
  localparam int FRM = W + PAR_BITS;

  logic clk = 1'b0;
  logic rst, s_valid, s_data, sync, m_ready;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sipo_deser_if #(.WIDTH(W)) bus_m ();
  sipo_deser_if #(.WIDTH(W)) bus_l ();

  assign bus_m.s_valid = s_valid;
  assign bus_m.s_data  = s_data;
  assign bus_m.sync    = sync;
  assign bus_m.m_ready = m_ready;
  assign bus_l.s_valid = s_valid;
  assign bus_l.s_data  = s_data;
  assign bus_l.sync    = sync;
  assign bus_l.m_ready = m_ready;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bus_m));
  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bus_l));

  // Reference model: the current frame is a list of received bits; a word is
  // built from that list once it holds a whole frame.
  bit         fbits[$];
  bit         pend_v, out_v, pend_p, out_p;
  logic [7:0] pend_m, pend_l, out_m, out_l;

  function automatic void assemble(output logic [7:0] wm, output logic [7:0] wl, output bit pe);
    wm = '0; wl = '0; pe = 1'b0;
    for (int i = 0; i < W; i++) begin
      wm[W-1-i] = fbits[i];
      wl[i]     = fbits[i];
      pe        = pe ^ fbits[i];
    end
    if (PAR_BITS == 1) pe = pe ^ fbits[W];
  endfunction

  task automatic model_edge();
    bit free;
    logic [7:0] wm, wl;
    bit pe;
    free = !out_v || m_ready;
    if (rst) begin
      fbits.delete();
      pend_v = 0; out_v = 0; out_m = '0; out_l = '0; out_p = 0;
    end else if (pend_v) begin
      if (free) begin
        out_v = 1; out_m = pend_m; out_l = pend_l; out_p = pend_p; pend_v = 0;
      end
    end else begin
      if (out_v && m_ready) out_v = 0;
      if (sync) fbits.delete();
      if (s_valid) begin
        fbits.push_back(s_data);
        if (fbits.size() == FRM) begin
          assemble(wm, wl, pe);
          fbits.delete();
          if (free) begin
            out_v = 1; out_m = wm; out_l = wl; out_p = pe;
          end else begin
            pend_v = 1; pend_m = wm; pend_l = wl; pend_p = pe;
          end
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    logic exp_srdy;
    model_edge();
    @(posedge clk);
    #1;
    exp_srdy = !rst && !pend_v;
    chk("msb s_ready", bus_m.s_ready, exp_srdy);
    chk("lsb s_ready", bus_l.s_ready, exp_srdy);
    chk("msb m_valid", bus_m.m_valid, out_v);
    chk("lsb m_valid", bus_l.m_valid, out_v);
    chk("msb m_data",  bus_m.m_data,  out_m);
    chk("lsb m_data",  bus_l.m_data,  out_l);
`ifdef SIPO_PARITY_EN
    chk("msb m_perr", bus_m.m_perr, out_p);
    chk("lsb m_perr", bus_l.m_perr, out_p);
`endif
  endtask

  // One frame, first bit = w[7]; a correct even-parity bit is appended when enabled.
  task automatic send_word(input logic [7:0] w, input bit quiet);
    for (int k = 0; k < FRM; k++) begin
      s_valid = 1'b1;
      s_data  = (k < W) ? w[W-1-k] : ^w;
      step();
      if (quiet && k < FRM - 1) chk("no early m_valid", bus_m.m_valid, 1'b0);
    end
    s_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] seq;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'b1011_0010, 8'hB2, 8'h4D};
    vecs[1] = '{8'b0000_0001, 8'h01, 8'h80};
    vecs[2] = '{8'b1111_0000, 8'hF0, 8'h0F};
    vecs[3] = '{8'b0001_0010, 8'h12, 8'h48};
    vecs[4] = '{8'b1010_0101, 8'hA5, 8'hA5};
    vecs[5] = '{8'b0110_1011, 8'h6B, 8'hD6};

    rst = 1'b1; s_valid = 1'b0; s_data = 1'b0; sync = 1'b0; m_ready = 1'b1;
    step(); step();
    chk("reset s_ready", bus_m.s_ready, 1'b0);
    chk("reset m_valid", bus_m.m_valid, 1'b0);
    chk("reset m_data",  bus_m.m_data, 8'h00);
    rst = 1'b0;
    step();
    chk("post-reset s_ready", bus_m.s_ready, 1'b1);

    // Streaming words with an always-ready sink.
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < FRM; k++) begin
        s_valid = 1'b1;
        s_data  = (k < W) ? vecs[v].seq[W-1-k] : ^vecs[v].seq;
        step();
        chk("stream s_ready", bus_m.s_ready, 1'b1);
        if (k < FRM - 1) chk("stream m_valid low", bus_l.m_valid, 1'b0);
      end
      chk("vec msb valid", bus_m.m_valid, 1'b1);
      chk("vec msb data",  bus_m.m_data, vecs[v].exp_m);
      chk("vec lsb data",  bus_l.m_data, vecs[v].exp_l);
`ifdef SIPO_PARITY_EN
      chk("vec perr", bus_m.m_perr, 1'b0);
`endif
    end
    s_valid = 1'b0;
    step();

    // Backpressure: second word parks in the shift stage.
    m_ready = 1'b0;
    send_word(8'hA5, 1'b1);
    chk("bp first valid", bus_m.m_valid, 1'b1);
    chk("bp first data",  bus_m.m_data, 8'hA5);
    send_word(8'h3C, 1'b0);
    chk("bp full s_ready", bus_m.s_ready, 1'b0);
    chk("bp held data",    bus_m.m_data, 8'hA5);
    s_valid = 1'b1; s_data = 1'b1;
    step(); step();
    chk("bp still held",   bus_l.m_data, 8'hA5);
    chk("bp still full",   bus_l.s_ready, 1'b0);
    s_valid = 1'b0; m_ready = 1'b1;
    step();
    chk("bp second data",  bus_m.m_data, 8'h3C);
    chk("bp second valid", bus_m.m_valid, 1'b1);
    chk("bp s_ready back", bus_m.s_ready, 1'b1);
    step();
    chk("bp drained", bus_m.m_valid, 1'b0);

    // Resync discards a partial word.
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_data = k[0];
      step();
    end
    s_valid = 1'b0; sync = 1'b1;
    step();
    sync = 1'b0;
    send_word(8'hFF, 1'b1);
    chk("sync word valid", bus_m.m_valid, 1'b1);
    chk("sync word data",  bus_l.m_data, 8'hFF);
    step();

    // Reset mid-word loses the partial frame.
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1; s_data = 1'b1;
      step();
    end
    s_valid = 1'b0; rst = 1'b1;
    step();
    chk("mid reset valid", bus_m.m_valid, 1'b0);
    rst = 1'b0;
    send_word(8'h5A, 1'b1);
    chk("after reset data", bus_m.m_data, 8'h5A);
    chk("after reset valid", bus_m.m_valid, 1'b1);
    step();

`ifdef SIPO_PARITY_EN
    for (int k = 0; k < FRM; k++) begin
      s_valid = 1'b1;
      s_data  = (k < W) ? vecs[0].seq[W-1-k] : 1'b1;
      step();
    end
    s_valid = 1'b0;
    chk("bad parity perr", bus_m.m_perr, 1'b1);
    chk("bad parity data", bus_m.m_data, 8'hB2);
    step();
`endif

    // Random traffic, sync and occasional reset against the model.
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      s_valid = ($urandom_range(0, 9) < 7);
      s_data  = 1'($urandom);
      sync    = ($urandom_range(0, 19) == 0);
      m_ready = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
